// File: rtl/mem_pkg.sv
// Shared encodings for the load/store front end: access sizes, FSM states and
// the latched request record, plus the alignment rule used by the top.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RD    = 3'd1;
    localparam logic [2:0] ST_LATCH = 3'd2;
    localparam logic [2:0] ST_WR    = 3'd3;
    localparam logic [2:0] ST_RESP  = 3'd4;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    // Size 2'b11 falls into the word case on purpose.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lane[0];
            default: return lane != 2'b00;
        endcase
    endfunction

    function automatic logic is_subword(input logic [1:0] size);
        return (size == SZ_BYTE) || (size == SZ_HALF);
    endfunction

endpackage

// File: rtl/subword_lane.sv
// Combinational lane logic: pulls a byte/half out of a RAM word with sign or
// zero extension, and merges store data into the addressed lane of a word.
module subword_lane
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        sgn,
    output logic [31:0] rdata,
    output logic [31:0] merged
);

    logic [7:0]         byte_sel;
    logic [15:0]        half_sel;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    always_comb begin
        byte_sel = word[{lane, 3'b000} +: 8];
        half_sel = lane[1] ? word[31:16] : word[15:0];
        byte_s   = signed'(byte_sel);
        half_s   = signed'(half_sel);

        case (size)
            SZ_BYTE: rdata = sgn ? 32'(byte_s) : {24'h0, byte_sel};
            SZ_HALF: rdata = sgn ? 32'(half_s) : {16'h0, half_sel};
            default: rdata = word;
        endcase

        // Untouched lanes keep the value just read from the RAM.
        merged = word;
        case (size)
            SZ_BYTE: merged[{lane, 3'b000} +: 8] = wdata[7:0];
            SZ_HALF: begin
                if (lane[1]) merged[31:16] = wdata[15:0];
                else         merged[15:0]  = wdata[15:0];
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end: turns one byte/half/word CPU access into aligned
// word cycles on the syncram, with read-modify-write for sub-word stores.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ALIGN_CHECK = 1,
    parameter int BUS_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_signed,
    input  logic [BUS_W-1:0] req_addr,
    input  logic [BUS_W-1:0] req_wdata,
    output logic             resp_valid,
    output logic [BUS_W-1:0] resp_rdata,
    output logic             resp_err,
    output logic             ram_cs,
    output logic             ram_oe,
    output logic             ram_we,
    output logic [BUS_W-1:0] ram_addr,
    output logic [BUS_W-1:0] ram_din,
    input  logic [BUS_W-1:0] ram_dout
);

    logic [2:0]       state;
    mem_req_t         req_q;
    logic [BUS_W-1:0] wbuf;
    logic [31:0]      lane_rdata;
    logic [31:0]      lane_merged;
    logic             req_mis;
    logic             q_mis;

    assign req_mis = (ALIGN_CHECK != 0) && misaligned(req_size, req_addr[1:0]);
    assign q_mis   = (ALIGN_CHECK != 0) && misaligned(req_q.size, req_q.addr[1:0]);

    // Strobes decode from state alone so the RAM is never touched outside RD/WR.
    assign req_ready = (state == ST_IDLE);
    assign ram_cs    = (state == ST_RD) || (state == ST_WR);
    assign ram_oe    = (state == ST_RD);
    assign ram_we    = (state == ST_WR);
    assign ram_addr  = {req_q.addr[31:2], 2'b00};
    assign ram_din   = wbuf;

    subword_lane u_lane (
        .word   (ram_dout),
        .wdata  (req_q.wdata),
        .lane   (req_q.addr[1:0]),
        .size   (req_q.size),
        .sgn    (req_q.sgn),
        .rdata  (lane_rdata),
        .merged (lane_merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            req_q      <= '0;
            wbuf       <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_q <= '{we: req_we, size: req_size, sgn: req_signed,
                                   addr: req_addr, wdata: req_wdata};
                        wbuf  <= req_wdata;
                        if (req_mis)                              state <= ST_RESP;
                        else if (!req_we || is_subword(req_size)) state <= ST_RD;
                        else                                      state <= ST_WR;
                    end
                end
                ST_RD:    state <= ST_LATCH;
                // wbuf carries either the merged store word or the extracted load data.
                ST_LATCH: begin
                    wbuf  <= req_q.we ? lane_merged : lane_rdata;
                    state <= req_q.we ? ST_WR : ST_RESP;
                end
                ST_WR:    state <= ST_RESP;
                ST_RESP: begin
                    resp_valid <= 1'b1;
                    resp_err   <= q_mis;
                    resp_rdata <= (q_mis || req_q.we) ? '0 : wbuf;
                    state      <= ST_IDLE;
                end
                default:  state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: pairs the unit with a small syncram and checks
// every cycle against a byte-addressed reference memory model.
module tb_mem_access_unit;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        ram_cs, ram_oe, ram_we;
    logic [31:0] ram_addr, ram_din, ram_dout;

    always #5 clk = ~clk;

    mem_access_unit #(.ALIGN_CHECK(1), .BUS_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .ram_cs(ram_cs), .ram_oe(ram_oe), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // Syncram: registered read, write on edge.
    logic        preload = 1'b1;
    logic [31:0] sram [0:255];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) sram[i] <= (i == 64) ? 32'h8899AABB : 32'h0;
        end else begin
            if (ram_cs && ram_we) sram[ram_addr[9:2]] <= ram_din;
            if (ram_cs && ram_oe) ram_dout <= sram[ram_addr[9:2]];
        end
    end

    typedef struct {
        int          due;
        logic [31:0] rdata;
        logic        err;
        int          cs_n;
        int          we_n;
        logic        st;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  ref_mem [0:1023];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          cs_cnt = 0;
    int          we_cnt = 0;
    int          we_total = 0;
    logic        acc_p = 1'b0;
    logic        p_we, p_sgn;
    logic [1:0]  p_size;
    logic [31:0] p_addr, p_wdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Expected response derived from byte-level memory contents and access rules.
    task automatic model_accept(input logic we, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata);
        exp_t       e;
        logic [9:0] a;
        logic [31:0] v;
        a = addr[9:0];
        v = 32'h0;
        e.due = cyc; e.rdata = 32'h0; e.err = 1'b0; e.cs_n = 0; e.we_n = 0;
        e.st = we; e.size = size; e.addr = addr; e.wdata = wdata;
        if ((size == SZ_HALF && addr[0]) || (size[1] && addr[1:0] != 2'b00)) begin
            e.err = 1'b1;
            e.due += 1;
        end else if (we) begin
            e.we_n = 1;
            if (size[1]) begin e.cs_n = 1; e.due += 2; end
            else         begin e.cs_n = 2; e.due += 4; end
        end else begin
            e.cs_n = 1;
            e.due += 3;
            case (size)
                SZ_BYTE: begin
                    v = {24'h0, ref_mem[a]};
                    if (sgn && v[7]) v |= 32'hFFFFFF00;
                end
                SZ_HALF: begin
                    v = {16'h0, ref_mem[a + 10'd1], ref_mem[a]};
                    if (sgn && v[15]) v |= 32'hFFFF0000;
                end
                default: v = {ref_mem[a + 10'd3], ref_mem[a + 10'd2], ref_mem[a + 10'd1], ref_mem[a]};
            endcase
            e.rdata = v;
        end
        q.push_back(e);
    endtask

    task automatic model_commit(input exp_t e);
        logic [9:0] a;
        a = e.addr[9:0];
        ref_mem[a] = e.wdata[7:0];
        if (e.size != SZ_BYTE) ref_mem[a + 10'd1] = e.wdata[15:8];
        if (e.size[1]) begin
            ref_mem[a + 10'd2] = e.wdata[23:16];
            ref_mem[a + 10'd3] = e.wdata[31:24];
        end
    endtask

    // Edge counter and acceptance monitor.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (acc_p && rst_n) model_accept(p_we, p_size, p_sgn, p_addr, p_wdata);
        end
    end

    // Per-cycle compare against the model.
    initial begin
        exp_t e;
        logic exp_v;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
        ref_mem[256] = 8'hBB; ref_mem[257] = 8'hAA; ref_mem[258] = 8'h99; ref_mem[259] = 8'h88;
        forever begin
            @(negedge clk);
            if (ram_we) we_total++;
            if (!rst_n) begin
                q.delete();
                cs_cnt = 0;
                we_cnt = 0;
            end else begin
                if (ram_cs) cs_cnt++;
                if (ram_we) we_cnt++;
                exp_v = (q.size() > 0) && (q[0].due == cyc);
                chk("resp_valid", resp_valid, exp_v);
                chk("req_ready", req_ready, (q.size() == 0) || exp_v);
                chk("cs_vs_oe_we", ram_cs, ram_oe | ram_we);
                if (exp_v) begin
                    e = q.pop_front();
                    chk("m_rdata", resp_rdata, e.rdata);
                    chk("m_err", resp_err, e.err);
                    chk("m_cs_cycles", cs_cnt, e.cs_n);
                    chk("m_we_pulses", we_cnt, e.we_n);
                    if (e.st && !e.err) model_commit(e);
                    cs_cnt = 0;
                    we_cnt = 0;
                end
            end
            acc_p   = req_valid && req_ready && rst_n;
            p_we    = req_we;
            p_size  = req_size;
            p_sgn   = req_signed;
            p_addr  = req_addr;
            p_wdata = req_wdata;
        end
    end

    task automatic send(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata);
        logic ok;
        ok = 1'b0;
        @(posedge clk); #1;
        req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; break; end
        end
        chk("accepted", ok, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output logic [31:0] rd, output logic er);
        logic got;
        got = 1'b0;
        rd = 32'hX;
        er = 1'bX;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (resp_valid) begin rd = resp_rdata; er = resp_err; got = 1'b1; break; end
        end
        chk("resp_arrived", got, 1'b1);
    endtask

    task automatic xact(input string nm, input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_er);
        logic [31:0] rd;
        logic        er;
        send(we, size, sgn, addr, wdata);
        wait_resp(rd, er);
        chk({nm, "_rdata"}, rd, exp_rd);
        chk({nm, "_err"}, er, exp_er);
    endtask

    task automatic back_to_back();
        logic [31:0] addrs [3];
        logic [1:0]  sizes [3];
        logic        sgns  [3];
        logic        ok;
        addrs[0] = 32'h100; sizes[0] = SZ_WORD; sgns[0] = 1'b0;
        addrs[1] = 32'h102; sizes[1] = SZ_HALF; sgns[1] = 1'b0;
        addrs[2] = 32'h101; sizes[2] = SZ_BYTE; sgns[2] = 1'b1;
        @(posedge clk); #1;
        req_we = 1'b0; req_size = sizes[0]; req_signed = sgns[0]; req_addr = addrs[0];
        req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (req_ready) begin ok = 1'b1; break; end
            end
            chk("b2b_accepted", ok, 1'b1);
            @(posedge clk); #1;
            if (k < 2) begin
                req_size = sizes[k + 1]; req_signed = sgns[k + 1]; req_addr = addrs[k + 1];
            end else begin
                req_valid = 1'b0;
            end
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (q.size() == 0) break;
        end
        chk("b2b_drained", q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        int we_before;
        repeat (3) @(posedge clk);
        @(negedge clk);
        preload = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_resp_err", resp_err, 1'b0);
        chk("rst_ram_strobes", {29'h0, ram_cs, ram_oe, ram_we}, 32'h0);
        chk("rst_ram_addr", ram_addr, 32'h0);
        chk("rst_ram_din", ram_din, 32'h0);

        xact("ld_w100",    1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0, 32'h8899AABB, 1'b0);
        xact("ld_b103s",   1'b0, SZ_BYTE, 1'b1, 32'h103, 32'h0, 32'hFFFFFF88, 1'b0);
        xact("ld_b103u",   1'b0, SZ_BYTE, 1'b0, 32'h103, 32'h0, 32'h00000088, 1'b0);
        xact("ld_h100s",   1'b0, SZ_HALF, 1'b1, 32'h100, 32'h0, 32'hFFFFAABB, 1'b0);
        xact("ld_h102u",   1'b0, SZ_HALF, 1'b0, 32'h102, 32'h0, 32'h00008899, 1'b0);
        xact("ld_b102u",   1'b0, SZ_BYTE, 1'b0, 32'h102, 32'h0, 32'h00000099, 1'b0);
        xact("st_b101",    1'b1, SZ_BYTE, 1'b0, 32'h101, 32'hFFFFFF5A, 32'h0, 1'b0);
        xact("ld_w100_b",  1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0, 32'h88995ABB, 1'b0);
        xact("ld_b101s",   1'b0, SZ_BYTE, 1'b1, 32'h101, 32'h0, 32'h0000005A, 1'b0);
        xact("ld_h101mis", 1'b0, SZ_HALF, 1'b1, 32'h101, 32'h0, 32'h0, 1'b1);
        xact("st_w102mis", 1'b1, SZ_WORD, 1'b0, 32'h102, 32'hDEADBEEF, 32'h0, 1'b1);
        xact("ld_w103mis", 1'b0, SZ_WORD, 1'b0, 32'h103, 32'h0, 32'h0, 1'b1);
        xact("ld_w100_c",  1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0, 32'h88995ABB, 1'b0);
        xact("st_w104",    1'b1, SZ_WORD, 1'b0, 32'h104, 32'h12345678, 32'h0, 1'b0);
        xact("st_h106",    1'b1, SZ_HALF, 1'b0, 32'h106, 32'hCAFEBEEF, 32'h0, 1'b0);
        xact("ld_w104",    1'b0, SZ_WORD, 1'b0, 32'h104, 32'h0, 32'hBEEF5678, 1'b0);
        xact("ld_h106s",   1'b0, SZ_HALF, 1'b1, 32'h106, 32'h0, 32'hFFFFBEEF, 1'b0);
        xact("ld_h104u",   1'b0, SZ_HALF, 1'b0, 32'h104, 32'h0, 32'h00005678, 1'b0);
        xact("st_b107",    1'b1, SZ_BYTE, 1'b0, 32'h107, 32'h00000011, 32'h0, 1'b0);
        xact("ld_w104s",   1'b0, SZ_WORD, 1'b1, 32'h104, 32'h0, 32'h11EF5678, 1'b0);
        xact("ld_sz3",     1'b0, 2'b11,   1'b1, 32'h104, 32'h0, 32'h11EF5678, 1'b0);
        xact("st_b108",    1'b1, SZ_BYTE, 1'b0, 32'h108, 32'hABCDEF77, 32'h0, 1'b0);
        xact("ld_w108",    1'b0, SZ_WORD, 1'b0, 32'h108, 32'h0, 32'h00000077, 1'b0);
        xact("ld_b10As",   1'b0, SZ_BYTE, 1'b1, 32'h10A, 32'h0, 32'h00000000, 1'b0);

        back_to_back();

        // Reset while a byte store to 0x100 sits in LATCH.
        we_before = we_total;
        send(1'b1, SZ_BYTE, 1'b0, 32'h100, 32'h000000EE);
        @(posedge clk); #2;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("mid_rst_resp_valid", resp_valid, 1'b0);
        chk("mid_rst_resp_rdata", resp_rdata, 32'h0);
        chk("mid_rst_strobes", {29'h0, ram_cs, ram_oe, ram_we}, 32'h0);
        chk("mid_rst_ram_addr", ram_addr, 32'h0);
        chk("mid_rst_ram_din", ram_din, 32'h0);
        chk("mid_rst_ready", req_ready, 1'b1);
        rst_n = 1'b1;
        chk("mid_rst_no_write", we_total, we_before);
        xact("ld_w100_rst", 1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0, 32'h88995ABB, 1'b0);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
